// File: rtl/bure_issue_ctrl.sv
// Issue/hazard controller between ID and EX of the BureCore pipeline.
// Tracks pending writebacks, stalls on RAW/WAW/in-flight limit, holds issue across control ops and flushes on redirect.
module bure_issue_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_dec_valid,
  input  logic [4:0]           i_rs1_addr,
  input  logic                 i_rs1_used,
  input  logic [4:0]           i_rs2_addr,
  input  logic                 i_rs2_used,
  input  logic                 i_rd_wen,
  input  logic [4:0]           i_rd_addr,
  input  logic                 i_is_ctrl_op,
  input  logic                 i_ex_ready,
  input  logic                 i_wb_valid,
  input  logic [4:0]           i_wb_addr,
  input  logic                 i_resolve_valid,
  input  logic                 i_resolve_taken,
  output logic                 o_issue_valid,
  output logic                 o_id_stall,
  output logic                 o_id_flush,
  output logic [31:0]          o_scoreboard,
  output logic [CNT_WIDTH-1:0] o_inflight
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned OW = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_CTRL,
    ST_FLUSH
  } state_t;

  state_t                 state, state_nxt;
  logic [FW-1:0]          flush_cnt, flush_cnt_nxt;
  logic [31:0]            wb_clr;
  logic [31:0]            sb_eff;
  logic [31:0]            set_mask;
  logic [31:0]            sb_nxt;
  logic                   wb_dec;
  logic                   raw;
  logic                   waw;
  logic                   full;
  logic                   fire;
  logic                   rd_set;
  logic [OW-1:0]          occ;
  logic [CNT_WIDTH-1:0]   inflight_nxt;

  // Hazard detection sees writebacks of this cycle as already done (write-first register file).
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    wb_clr = '0;
    if (i_wb_valid && i_wb_addr != 5'd0) wb_clr[i_wb_addr] = 1'b1;
    sb_eff = o_scoreboard & ~wb_clr;
    // A writeback only frees a slot when it retires a pending entry.
    wb_dec = |(o_scoreboard & wb_clr);

    raw = (i_rs1_used && i_rs1_addr != 5'd0 && sb_eff[i_rs1_addr]) ||
          (i_rs2_used && i_rs2_addr != 5'd0 && sb_eff[i_rs2_addr]);
    waw = i_rd_wen && i_rd_addr != 5'd0 && sb_eff[i_rd_addr];

    occ  = {1'b0, o_inflight} - OW'(wb_dec);
    full = occ >= OW'(MAX_INFLIGHT);

    fire = i_rstn && state == ST_RUN && i_dec_valid && !raw && !waw && !full && i_ex_ready;
    o_issue_valid = fire;
    o_id_stall    = i_rstn && i_dec_valid && !fire && state != ST_FLUSH;

    rd_set   = fire && i_rd_wen && i_rd_addr != 5'd0;
    set_mask = '0;
    if (rd_set) set_mask[i_rd_addr] = 1'b1;
    sb_nxt    = sb_eff | set_mask;
    sb_nxt[0] = 1'b0;

    unique case ({rd_set, wb_dec})
      2'b10:   inflight_nxt = o_inflight + CNT_WIDTH'(1);
      2'b01:   inflight_nxt = o_inflight - CNT_WIDTH'(1);
      default: inflight_nxt = o_inflight;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    unique case (state)
      ST_RUN: begin
        if (fire && i_is_ctrl_op) state_nxt = ST_WAIT_CTRL;
      end
      ST_WAIT_CTRL: begin
        if (i_resolve_valid) begin
          if (i_resolve_taken) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FW'(FLUSH_CYCLES - 1);
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) state_nxt = ST_RUN;
        else                 flush_cnt_nxt = flush_cnt - FW'(1);
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= ST_RUN;
      flush_cnt    <= '0;
      o_id_flush   <= 1'b0;
      o_scoreboard <= '0;
      o_inflight   <= '0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      o_id_flush   <= (state_nxt == ST_FLUSH);
      o_scoreboard <= sb_nxt;
      o_inflight   <= inflight_nxt;
    end
  end

endmodule

// File: tb/tb_bure_issue_ctrl.sv
// Self-checking bench for bure_issue_ctrl: directed scenarios then randomized traffic,
// compared against a pending-register/flush-counter reference model.
module tb_bure_issue_ctrl;

  localparam int MAX_INFLIGHT = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_WIDTH    = 5;

  logic                 i_clk = 1'b0;
  logic                 i_rstn = 1'b0;
  logic                 i_dec_valid, i_rs1_used, i_rs2_used, i_rd_wen, i_is_ctrl_op;
  logic                 i_ex_ready, i_wb_valid, i_resolve_valid, i_resolve_taken;
  logic [4:0]           i_rs1_addr, i_rs2_addr, i_rd_addr, i_wb_addr;
  logic                 o_issue_valid, o_id_stall, o_id_flush;
  logic [31:0]          o_scoreboard;
  logic [CNT_WIDTH-1:0] o_inflight;

  bure_issue_ctrl #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_dec_valid    (i_dec_valid),
    .i_rs1_addr     (i_rs1_addr),
    .i_rs1_used     (i_rs1_used),
    .i_rs2_addr     (i_rs2_addr),
    .i_rs2_used     (i_rs2_used),
    .i_rd_wen       (i_rd_wen),
    .i_rd_addr      (i_rd_addr),
    .i_is_ctrl_op   (i_is_ctrl_op),
    .i_ex_ready     (i_ex_ready),
    .i_wb_valid     (i_wb_valid),
    .i_wb_addr      (i_wb_addr),
    .i_resolve_valid(i_resolve_valid),
    .i_resolve_taken(i_resolve_taken),
    .o_issue_valid  (o_issue_valid),
    .o_id_stall     (o_id_stall),
    .o_id_flush     (o_id_flush),
    .o_scoreboard   (o_scoreboard),
    .o_inflight     (o_inflight)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: set of registers awaiting writeback, a pending-branch flag, flush cycles left.
  bit pend[32];
  int n_pend;
  bit ctrl_wait;
  int flush_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend[r]) pend[r] = 1'b0;
    n_pend     = 0;
    ctrl_wait  = 1'b0;
    flush_left = 0;
  endtask

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && pend[r] && !(i_wb_valid && i_wb_addr == r);
  endfunction

  function automatic bit exp_fire();
    bit freed, raw, waw, full;
    freed = i_wb_valid && i_wb_addr != 0 && pend[i_wb_addr];
    raw   = (i_rs1_used && busy(i_rs1_addr)) || (i_rs2_used && busy(i_rs2_addr));
    waw   = i_rd_wen && busy(i_rd_addr);
    full  = (n_pend - int'(freed)) >= MAX_INFLIGHT;
    return i_rstn && !ctrl_wait && flush_left == 0 && i_dec_valid && !raw && !waw && !full && i_ex_ready;
  endfunction

  task automatic model_clock(input bit f);
    if (i_wb_valid && i_wb_addr != 0 && pend[i_wb_addr]) begin
      pend[i_wb_addr] = 1'b0;
      n_pend--;
    end
    if (f && i_rd_wen && i_rd_addr != 0) begin
      pend[i_rd_addr] = 1'b1;
      n_pend++;
    end
    if (flush_left > 0) flush_left--;
    else if (ctrl_wait && i_resolve_valid) begin
      ctrl_wait = 1'b0;
      if (i_resolve_taken) flush_left = FLUSH_CYCLES;
    end else if (f && i_is_ctrl_op) ctrl_wait = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] sb;
    sb = '0;
    for (int r = 0; r < 32; r++) sb[r] = pend[r];
    check({tag, ".sb"}, o_scoreboard, sb);
    check({tag, ".inflight"}, 32'(o_inflight), 32'(n_pend));
    check({tag, ".flush"}, 32'(o_id_flush), 32'(flush_left > 0));
  endtask

  // One clock: check combinational outputs, clock edge, update model, check registered outputs.
  task automatic step(input string tag);
    bit f, s;
    #1;
    f = exp_fire();
    s = i_dec_valid && !f && flush_left == 0;
    check({tag, ".issue"}, 32'(o_issue_valid), 32'(f));
    check({tag, ".stall"}, 32'(o_id_stall), 32'(s));
    @(posedge i_clk);
    model_clock(f);
    #1;
    check_regs(tag);
  endtask

  task automatic idle();
    i_dec_valid = 0; i_rs1_used = 0; i_rs2_used = 0; i_rd_wen = 0; i_is_ctrl_op = 0;
    i_ex_ready = 1; i_wb_valid = 0; i_resolve_valid = 0; i_resolve_taken = 0;
    i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0; i_wb_addr = 0;
  endtask

  task automatic writer(input logic [4:0] rd);
    idle();
    i_dec_valid = 1; i_rd_wen = 1; i_rd_addr = rd;
  endtask

  task automatic writeback(input logic [4:0] a);
    idle();
    i_wb_valid = 1; i_wb_addr = a;
  endtask

  task automatic branch();
    idle();
    i_dec_valid = 1; i_is_ctrl_op = 1; i_rs1_used = 1; i_rs1_addr = 5'd10;
  endtask

  initial begin
    idle();
    model_reset();
    i_dec_valid = 1;
    #12;
    check("reset.sb", o_scoreboard, 32'h0);
    check("reset.inflight", 32'(o_inflight), 32'h0);
    check("reset.flush", 32'(o_id_flush), 32'h0);
    check("reset.issue", 32'(o_issue_valid), 32'h0);
    check("reset.stall", 32'(o_id_stall), 32'h0);
    i_rstn = 1;

    // addi x5
    writer(5'd5);
    step("addi_x5");
    check("addi_x5.sb_const", o_scoreboard, 32'h0000_0020);
    check("addi_x5.inflight_const", 32'(o_inflight), 32'd1);

    // add x6,x5,x1: RAW stall, then same-cycle writeback of x5 releases it
    writer(5'd6); i_rs1_used = 1; i_rs1_addr = 5'd5; i_rs2_used = 1; i_rs2_addr = 5'd1;
    step("raw_stall");
    i_wb_valid = 1; i_wb_addr = 5'd5;
    step("raw_wb_bypass");
    check("raw_wb_bypass.sb_const", o_scoreboard, 32'h0000_0040);
    writeback(5'd6);
    step("drain_x6");

    // In-flight limit
    for (int r = 1; r <= 4; r++) begin
      writer(5'(r));
      step("fill");
    end
    writer(5'd7);
    step("full_stall");
    check("full_stall.inflight_const", 32'(o_inflight), 32'd4);
    i_wb_valid = 1; i_wb_addr = 5'd1;
    step("full_wb_release");
    check("full_wb_release.inflight_const", 32'(o_inflight), 32'd4);
    for (int r = 2; r <= 7; r++) begin
      writeback(5'(r));
      step("drain");
    end

    // Branch not taken
    branch();
    step("br_nt_issue");
    writer(5'd8);
    step("br_nt_wait_stall");
    i_resolve_valid = 1; i_resolve_taken = 0;
    step("br_nt_resolve");
    i_resolve_valid = 0;
    step("br_nt_resume");
    check("br_nt_resume.issue_seen", o_scoreboard, 32'h0000_0100);

    // Branch taken: two flush cycles, decode present throughout
    branch();
    step("br_t_issue");
    idle();
    i_dec_valid = 1; i_resolve_valid = 1; i_resolve_taken = 1;
    step("br_t_resolve");
    i_resolve_valid = 0; i_resolve_taken = 0;
    step("br_t_flush1");
    step("br_t_flush2");
    check("br_t_flush2.flush_const", 32'(o_id_flush), 32'h0);
    writer(5'd9);
    step("br_t_run");

    // x0 handling
    writer(5'd0); i_rs1_used = 1; i_rs1_addr = 5'd0; i_wb_valid = 1; i_wb_addr = 5'd0;
    step("x0_writer");
    check("x0_writer.bit0", 32'(o_scoreboard[0]), 32'h0);
    writeback(5'd12);
    step("stale_wb");

    // Reset in the middle of a flush
    branch();
    step("rst_br_issue");
    idle();
    i_resolve_valid = 1; i_resolve_taken = 1;
    step("rst_br_resolve");
    idle();
    i_dec_valid = 1;
    #2;
    i_rstn = 0;
    #1;
    model_reset();
    check("rst_flush.flush", 32'(o_id_flush), 32'h0);
    check("rst_flush.sb", o_scoreboard, 32'h0);
    check("rst_flush.inflight", 32'(o_inflight), 32'h0);
    check("rst_flush.issue", 32'(o_issue_valid), 32'h0);
    check("rst_flush.stall", 32'(o_id_stall), 32'h0);
    @(negedge i_clk);
    i_rstn = 1;

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      i_dec_valid     = $urandom_range(0, 3) != 0;
      i_rs1_used      = $urandom_range(0, 1) != 0;
      i_rs1_addr      = 5'($urandom_range(0, 7));
      i_rs2_used      = $urandom_range(0, 1) != 0;
      i_rs2_addr      = 5'($urandom_range(0, 7));
      i_rd_wen        = $urandom_range(0, 3) != 0;
      i_rd_addr       = 5'($urandom_range(0, 7));
      i_is_ctrl_op    = $urandom_range(0, 9) == 0;
      i_ex_ready      = $urandom_range(0, 4) != 0;
      i_wb_valid      = $urandom_range(0, 1) != 0;
      i_wb_addr       = 5'($urandom_range(0, 7));
      i_resolve_valid = $urandom_range(0, 3) == 0;
      i_resolve_taken = $urandom_range(0, 1) != 0;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
